// File: rtl/rsbus_d2r_req_sched.sv
// rsbus_d2r_req_sched
//   Credit-based request scheduler between a request-FIFO bank head and the
//   ring. A head is granted when the scheduler is enabled and its requester
//   still has credit. The grant is held until the ring accepts it. The FIFO
//   head is then popped, and a fixed number of dead cycles follows.
//   Completions return credits.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_en                enable; low blocks new grants only
//   i_stb/i_prior/i_req/i_rid   FIFO-bank head (valid, priority, code, id)
//   i_ack                 one-cycle pop pulse toward the FIFO bank
//   g_stb/g_prior/g_req/g_rid   grant toward the ring (held until g_ack)
//   g_ack                 ring accepted the grant
//   c_stb/c_rid           completion, releases one credit of c_rid
//   o_stall               head blocked for STALL_LIMIT cycles
//   o_err                 sticky credit-underflow error
module rsbus_d2r_req_sched #(
  parameter int MAX_OUT     = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int STALL_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_en,
  input  logic       i_stb,
  input  logic [1:0] i_prior,
  input  logic [3:0] i_req,
  input  logic [3:0] i_rid,
  output logic       i_ack,
  output logic       g_stb,
  output logic [1:0] g_prior,
  output logic [3:0] g_req,
  output logic [3:0] g_rid,
  input  logic       g_ack,
  input  logic       c_stb,
  input  logic [3:0] c_rid,
  output logic       o_stall,
  output logic       o_err
);

  localparam logic [2:0] LP_MAX   = 3'(MAX_OUT);
  localparam logic [3:0] LP_HOLD  = 4'(HOLD_CYCLES);
  localparam logic [7:0] LP_STALL = 8'(STALL_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [2:0] r_credit [16];
  logic [3:0] r_hold;
  logic [3:0] w_hold_nxt;
  logic [7:0] r_stall;
  logic [7:0] w_stall_nxt;

  logic       r_g_stb;
  logic       r_i_ack;
  logic [1:0] r_g_prior;
  logic [3:0] r_g_req;
  logic [3:0] r_g_rid;
  logic       r_o_stall;
  logic       r_o_err;

  logic       w_g_stb_nxt;
  logic       w_i_ack_nxt;
  logic [1:0] w_g_prior_nxt;
  logic [3:0] w_g_req_nxt;
  logic [3:0] w_g_rid_nxt;

  logic       w_grant;
  logic       w_accept;
  logic       w_underflow;

  assign w_grant  = (r_state == ST_IDLE) & i_stb & cfg_en & (r_credit[i_rid] < LP_MAX);
  assign w_accept = (r_state == ST_ISSUE) & g_ack;
  // A same-cycle grant increment on the completing rid absorbs the decrement.
  assign w_underflow = c_stb & (r_credit[c_rid] == 3'd0) & ~(w_accept & (r_g_rid == c_rid));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (g_ack) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (r_hold <= 4'd1) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / counter next values (all outputs are registered below)
  always_comb begin
    w_g_stb_nxt   = r_g_stb;
    w_i_ack_nxt   = 1'b0;
    w_g_prior_nxt = r_g_prior;
    w_g_req_nxt   = r_g_req;
    w_g_rid_nxt   = r_g_rid;
    w_hold_nxt    = r_hold;
    w_stall_nxt   = r_stall;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_g_stb_nxt   = 1'b1;
          w_g_prior_nxt = i_prior;
          w_g_req_nxt   = i_req;
          w_g_rid_nxt   = i_rid;
        end
        if (!i_stb || w_grant) begin
          w_stall_nxt = '0;
        end else if (r_stall != LP_STALL) begin
          w_stall_nxt = r_stall + 8'd1;
        end
      end
      ST_ISSUE: begin
        if (g_ack) begin
          w_g_stb_nxt = 1'b0;
          w_i_ack_nxt = 1'b1;
          w_hold_nxt  = LP_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_hold != 4'd0) w_hold_nxt = r_hold - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g_stb   <= 1'b0;
      r_i_ack   <= 1'b0;
      r_g_prior <= '0;
      r_g_req   <= '0;
      r_g_rid   <= '0;
      r_hold    <= '0;
      r_stall   <= '0;
      r_o_stall <= 1'b0;
      r_o_err   <= 1'b0;
    end else begin
      r_g_stb   <= w_g_stb_nxt;
      r_i_ack   <= w_i_ack_nxt;
      r_g_prior <= w_g_prior_nxt;
      r_g_req   <= w_g_req_nxt;
      r_g_rid   <= w_g_rid_nxt;
      r_hold    <= w_hold_nxt;
      r_stall   <= w_stall_nxt;
      r_o_stall <= (w_stall_nxt == LP_STALL);
      if (w_underflow) r_o_err <= 1'b1;
    end
  end

  // Credit counters: +1 on ring acceptance, -1 on completion, floor at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) r_credit[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if ((w_accept && (r_g_rid == 4'(i))) && !(c_stb && (c_rid == 4'(i)))) begin
          if (r_credit[i] < LP_MAX) r_credit[i] <= r_credit[i] + 3'd1;
        end else if (!(w_accept && (r_g_rid == 4'(i))) && (c_stb && (c_rid == 4'(i)))) begin
          if (r_credit[i] != 3'd0) r_credit[i] <= r_credit[i] - 3'd1;
        end
      end
    end
  end

  assign g_stb   = r_g_stb;
  assign i_ack   = r_i_ack;
  assign g_prior = r_g_prior;
  assign g_req   = r_g_req;
  assign g_rid   = r_g_rid;
  assign o_stall = r_o_stall;
  assign o_err   = r_o_err;

endmodule
